// File: rtl/wo_reg_programmer.sv
// wo_reg_programmer
//   Initiator-side sequencer for a write-once lock register. On a start
//   pulse it checks the target's lock bit, issues a single write strobe,
//   lets the target settle, then reads back and verifies. A mismatch on a
//   target that is still unlocked triggers a bounded number of re-writes.
//
// Ports
//   Clk        in   1      clock, rising edge
//   ip_resetn  in   1      asynchronous active-low reset
//   start      in   1      request pulse, sampled only in IDLE
//   cfg_data   in   WIDTH  value to program (bit 0 ignored)
//   lock       in   1      1 = set the lock bit with this write
//   reg_rdata  in   WIDTH  target register readback (bit 0 = lock/status)
//   reg_write  out  1      registered write strobe to the target
//   reg_wdata  out  WIDTH  registered write data {cfg[WIDTH-1:1], lock}
//   busy       out  1      high whenever the sequencer is not IDLE
//   done       out  1      one-cycle completion pulse
//   err_code   out  2      00 ok, 01 already locked, 10 verify fail
//   locked     out  1      reg_rdata[0] as seen at the last check/verify
//   dbg_state  out  3      current FSM state, for observation only
//
// Handshake: start is a level sampled once per cycle while IDLE; done is a
// single-cycle pulse and err_code/locked are valid from done until the
// next accepted start.
module wo_reg_programmer #(
    parameter int WIDTH         = 16,
    parameter int MAX_RETRY     = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             ip_resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             lock,
    input  logic [WIDTH-1:0] reg_rdata,
    output logic             reg_write,
    output logic [WIDTH-1:0] reg_wdata,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code,
    output logic             locked,
    output logic [2:0]       dbg_state
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRY);

    // REJECT pads the already-locked path so its done lands two edges
    // after start, keeping PRECHECK a single-cycle decision.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRECHECK = 3'd1,
        WRITE    = 3'd2,
        SETTLE   = 3'd3,
        VERIFY   = 3'd4,
        REJECT   = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:1] cfg_q, cfg_d;
    logic             lock_q, lock_d;
    logic [CW-1:0]    settle_q, settle_d;
    logic [2:0]       retry_q, retry_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]       err_q, err_d;
    logic             locked_q, locked_d;
    logic [WIDTH-1:0] exp_val;

    // cfg_data[0] is replaced by the lock request and never used.
    logic unused_cfg_bit0;
    assign unused_cfg_bit0 = cfg_data[0];

    assign exp_val = {cfg_q, lock_q};

    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            lock_q   <= 1'b0;
            settle_q <= '0;
            retry_q  <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 2'b00;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            lock_q   <= lock_d;
            settle_q <= settle_d;
            retry_q  <= retry_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        lock_d   = lock_q;
        settle_d = settle_q;
        retry_d  = retry_q;
        wr_d     = 1'b0;
        wdata_d  = wdata_q;
        err_d    = err_q;
        locked_d = locked_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d   = cfg_data[WIDTH-1:1];
                    lock_d  = lock;
                    err_d   = 2'b00;
                    state_d = PRECHECK;
                end
            end
            PRECHECK: begin
                locked_d = reg_rdata[0];
                if (reg_rdata[0]) begin
                    err_d   = 2'b01;
                    state_d = REJECT;
                end else begin
                    // Strobe is registered: raise it on entry to WRITE.
                    wr_d    = 1'b1;
                    wdata_d = exp_val;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                settle_d = SETTLE_LOAD;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = VERIFY;
                end else begin
                    settle_d = settle_q - CW'(1);
                end
            end
            VERIFY: begin
                locked_d = reg_rdata[0];
                if (reg_rdata == exp_val) begin
                    err_d   = 2'b00;
                    state_d = DONE;
                end else if (!reg_rdata[0] && (retry_q < RETRY_MAX)) begin
                    retry_d = retry_q + 3'd1;
                    wr_d    = 1'b1;
                    wdata_d = exp_val;
                    state_d = WRITE;
                end else begin
                    err_d   = 2'b10;
                    state_d = DONE;
                end
            end
            REJECT: begin
                state_d = DONE;
            end
            DONE: begin
                retry_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign reg_write = wr_q;
    assign reg_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err_code  = err_q;
    assign locked    = locked_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wo_reg_programmer.sv
module tb_wo_reg_programmer;

  logic        Clk = 1'b0;
  logic        ip_resetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        lock = 1'b0;
  logic [15:0] reg_rdata;
  logic        reg_write;
  logic [15:0] reg_wdata;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic        locked;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- write-once target model ----------------
  logic [15:0] tgt = '0;
  logic        tgt_clr = 1'b0;
  logic        force_bad = 1'b0;
  int          wr_cnt = 0;
  logic [15:0] last_wdata = '0;

  always @(posedge Clk) begin
    if (tgt_clr) tgt <= '0;
    else if (reg_write && !tgt[0]) tgt <= reg_wdata;
    if (reg_write) begin
      wr_cnt <= wr_cnt + 1;
      last_wdata <= reg_wdata;
    end
  end

  assign reg_rdata = force_bad ? 16'hDEAC : tgt;

  wo_reg_programmer #(.WIDTH(16), .MAX_RETRY(2), .SETTLE_CYCLES(2)) dut (
    .Clk(Clk), .ip_resetn(ip_resetn), .start(start), .cfg_data(cfg_data),
    .lock(lock), .reg_rdata(reg_rdata), .reg_write(reg_write),
    .reg_wdata(reg_wdata), .busy(busy), .done(done), .err_code(err_code),
    .locked(locked), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_target();
    @(posedge Clk); #1 tgt_clr = 1'b1;
    @(posedge Clk); #1 tgt_clr = 1'b0;
  endtask

  // Returns after the edge that samples start (plus #1).
  task automatic pulse_start(input logic [15:0] c, input logic l);
    @(posedge Clk); #1;
    start = 1'b1; cfg_data = c; lock = l;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge Clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", reg_write); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", err_code); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    total++; if (reg_wdata !== 16'h0000) begin bad++; $display("FAIL reset_wdata got=%h exp=0000", reg_wdata); end
    @(posedge Clk); #1 ip_resetn = 1'b1;
  endtask

  task automatic test_clean_lock();
    int lat, w0;
    clear_target();
    w0 = wr_cnt;
    pulse_start(16'hA5A4, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", busy); end
    @(posedge Clk); #1;
    total++; if (reg_write !== 1'b1 || reg_wdata !== 16'hA5A5) begin bad++; $display("FAIL t1_strobe got=%b/%h exp=1/a5a5", reg_write, reg_wdata); end
    wait_done(lat);
    lat = (lat < 0) ? lat : lat + 1;
    total++; if (lat !== 5) begin bad++; $display("FAIL t1_latency got=%0d exp=5", lat); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL t1_err got=%b exp=00", err_code); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL t1_locked got=%b exp=1", locked); end
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL t1_writes got=%0d exp=1", wr_cnt - w0); end
    total++; if (tgt !== 16'hA5A5) begin bad++; $display("FAIL t1_target got=%h exp=a5a5", tgt); end
    @(posedge Clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL t1_idle got=%b/%b exp=0/0", busy, done); end
  endtask

  task automatic test_already_locked();
    int lat, w0;
    w0 = wr_cnt;
    pulse_start(16'h1234, 1'b1);
    wait_done(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL t2_latency got=%0d exp=2", lat); end
    total++; if (err_code !== 2'b01) begin bad++; $display("FAIL t2_err got=%b exp=01", err_code); end
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL t2_writes got=%0d exp=0", wr_cnt - w0); end
    total++; if (tgt !== 16'hA5A5) begin bad++; $display("FAIL t2_target got=%h exp=a5a5", tgt); end
    @(posedge Clk); #1;
    total++; if (err_code !== 2'b01) begin bad++; $display("FAIL t2_err_hold got=%b exp=01", err_code); end
  endtask

  task automatic test_unlocked_then_lock();
    int lat;
    clear_target();
    pulse_start(16'h00F0, 1'b0);
    wait_done(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL t3a_latency got=%0d exp=5", lat); end
    total++; if (err_code !== 2'b00 || locked !== 1'b0) begin bad++; $display("FAIL t3a_status got=%b/%b exp=00/0", err_code, locked); end
    total++; if (tgt !== 16'h00F0) begin bad++; $display("FAIL t3a_target got=%h exp=00f0", tgt); end
    pulse_start(16'h0F00, 1'b1);
    wait_done(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL t3b_latency got=%0d exp=5", lat); end
    total++; if (err_code !== 2'b00 || locked !== 1'b1) begin bad++; $display("FAIL t3b_status got=%b/%b exp=00/1", err_code, locked); end
    total++; if (reg_rdata !== 16'h0F01) begin bad++; $display("FAIL t3b_rdata got=%h exp=0f01", reg_rdata); end
  endtask

  task automatic test_retry_exhaust();
    int lat, w0;
    clear_target();
    force_bad = 1'b1;
    w0 = wr_cnt;
    pulse_start(16'h5550, 1'b0);
    wait_done(lat);
    total++; if (lat !== 13) begin bad++; $display("FAIL t4_latency got=%0d exp=13", lat); end
    total++; if (err_code !== 2'b10) begin bad++; $display("FAIL t4_err got=%b exp=10", err_code); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL t4_locked got=%b exp=0", locked); end
    total++; if (wr_cnt - w0 !== 3) begin bad++; $display("FAIL t4_writes got=%0d exp=3", wr_cnt - w0); end
    force_bad = 1'b0;
  endtask

  task automatic test_restart_ignored();
    int lat, w0;
    clear_target();
    w0 = wr_cnt;
    pulse_start(16'h1110, 1'b1);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge Clk); #1;
      if (k == 2) begin start = 1'b1; cfg_data = 16'h2220; lock = 1'b0; end
      if (k == 3) start = 1'b0;
      if (done) begin lat = k; break; end
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL t5_latency got=%0d exp=5", lat); end
    total++; if (tgt !== 16'h1111) begin bad++; $display("FAIL t5_target got=%h exp=1111", tgt); end
    total++; if (last_wdata !== 16'h1111) begin bad++; $display("FAIL t5_wdata got=%h exp=1111", last_wdata); end
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL t5_writes got=%0d exp=1", wr_cnt - w0); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL t5_err got=%b exp=00", err_code); end
    @(posedge Clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    clear_target();
    pulse_start(16'h4444, 1'b1);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    total++; if (busy !== 1'b1 || reg_write !== 1'b0) begin bad++; $display("FAIL t6_settle got=%b/%b exp=1/0", busy, reg_write); end
    ip_resetn = 1'b0;
    #1;
    total++; if (reg_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL t6_async got=%b/%b/%b exp=0/0/0", reg_write, busy, done); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL t6_err got=%b exp=00", err_code); end
    total++; if (tgt !== 16'h4445) begin bad++; $display("FAIL t6_target got=%h exp=4445", tgt); end
    @(posedge Clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL t6_nodone got=%b exp=0", done); end
    @(posedge Clk); #1 ip_resetn = 1'b1;
    clear_target();
    pulse_start(16'h3C3C, 1'b1);
    wait_done(lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL t6_rerun_latency got=%0d exp=5", lat); end
    total++; if (err_code !== 2'b00 || tgt !== 16'h3C3D) begin bad++; $display("FAIL t6_rerun got=%b/%h exp=00/3c3d", err_code, tgt); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_clean_lock();
    test_already_locked();
    test_unlocked_then_lock();
    test_retry_exhaust();
    test_restart_ignored();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
